// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART state encoding, bit-timing and parity helpers
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP1  = 3'd4,
        STOP2  = 3'd5
    } uart_state_t;

    // One bit period is calc_cycle()+1 clocks, so both ends count 0..CYCLE.
    function automatic int calc_cycle(input int clk_fre, input int baud_rate);
        return (clk_fre * 1000000) / baud_rate;
    endfunction

    function automatic int calc_half(input int cycle);
        return cycle / 2;
    endfunction

    function automatic logic odd_parity(input logic [7:0] data);
        return ~^data;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// rtl/uart_rx_sync.sv - rxd synchronizer, falling-edge detect and arming flag
module uart_rx_sync (
    input  logic clk,
    input  logic rst,
    input  logic rxd,
    output logic rxs,
    output logic fall
);

    logic sync_1;
    logic sync_2;
    logic prev;
    logic armed;

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
            prev   <= 1'b0;
            armed  <= 1'b0;
        end else begin
            sync_1 <= rxd;
            sync_2 <= sync_1;
            prev   <= sync_2;
            // A line stuck low since reset never arms, so it can never look like a start.
            armed  <= armed | sync_2;
        end
    end

    assign rxs  = sync_2;
    assign fall = armed & prev & ~sync_2;

endmodule

// File: rtl/uart_rx_frame.sv
// rtl/uart_rx_frame.sv - UART frame receiver with optional odd parity and 1/2 stop bits
module uart_rx_frame
    import uart_pkg::*;
#(
    parameter int CLK_FRE   = 50,
    parameter int BAUD_RATE = 9600
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable_ctrl,
    input  logic       odd_ctrl,
    input  logic       stop_ctrl,
    input  logic       rxd,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       parity_err,
    output logic       frame_err,
    output logic       busy
);

    localparam int CYCLE = calc_cycle(CLK_FRE, BAUD_RATE);
    localparam int HALF  = calc_half(CYCLE);
    localparam int TW    = $clog2(CYCLE + 1);
    localparam logic [TW-1:0] CYCLE_T = TW'(CYCLE);
    localparam logic [TW-1:0] HALF_T  = TW'(HALF);

    uart_state_t   state;
    uart_state_t   next_state;
    logic [TW-1:0] timer;
    logic [2:0]    idx;
    logic [7:0]    shift;
    logic          odd_q;
    logic          stop2_q;
    logic          perr_q;
    logic          ferr_q;
    logic          rxs;
    logic          fall;
    logic          sample;
    logic          stop_low;
    logic          complete;

    uart_rx_sync u_sync (
        .clk  (clk),
        .rst  (rst),
        .rxd  (rxd),
        .rxs  (rxs),
        .fall (fall)
    );

    assign sample   = (timer == HALF_T);
    assign stop_low = sample && !rxs && (state == STOP1 || state == STOP2);
    assign busy     = (state != IDLE);

    always_comb begin
        next_state = state;
        complete   = 1'b0;
        case (state)
            IDLE:   if (fall && !enable_ctrl) next_state = START;
            START:  if (sample) next_state = rxs ? IDLE : DATA;
            DATA:   if (sample && idx == 3'd7) next_state = odd_q ? PARITY : STOP1;
            PARITY: if (sample) next_state = STOP1;
            STOP1: begin
                // With one stop bit, leave at mid-bit so drift toward the next start is absorbed.
                if (sample) begin
                    if (stop2_q) begin
                        next_state = STOP2;
                    end else begin
                        next_state = IDLE;
                        complete   = 1'b1;
                    end
                end
            end
            STOP2: begin
                if (sample) begin
                    next_state = IDLE;
                    complete   = 1'b1;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            timer      <= '0;
            idx        <= 3'd0;
            shift      <= 8'd0;
            odd_q      <= 1'b0;
            stop2_q    <= 1'b0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            rx_data    <= 8'd0;
            rx_valid   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state    <= next_state;
            rx_valid <= complete;

            if (state == IDLE || timer == CYCLE_T) timer <= '0;
            else                                   timer <= timer + 1'b1;

            if (state == IDLE && next_state == START) begin
                odd_q   <= odd_ctrl;
                stop2_q <= stop_ctrl;
                idx     <= 3'd0;
                perr_q  <= 1'b0;
                ferr_q  <= 1'b0;
            end

            if (state == DATA && sample) begin
                shift <= {rxs, shift[7:1]};
                idx   <= idx + 3'd1;
            end

            if (state == PARITY && sample) perr_q <= rxs ^ odd_parity(shift);
            if (stop_low)                  ferr_q <= 1'b1;

            if (complete) begin
                rx_data    <= shift;
                parity_err <= perr_q;
                frame_err  <= ferr_q | stop_low;
            end
        end
    end

endmodule

// File: doc/uart_rx_frame.md
# uart_rx_frame

Serial receiver that consumes the TX serial line (`txd` of the transmit stage, looped or via pin) and recovers 8-bit frames with optional odd parity and one or two stop bits. The frame format controls match the transmit stage, so both ends can be driven from the same control register. Each received frame is delivered as a one-cycle `rx_valid` strobe with data and error flags to the downstream consumer, such as a FIFO or register bank.

## Interface
- `CLK_FRE`, default 50: system clock in MHz.
- `BAUD_RATE`, default 9600: line rate.
- `CYCLE` (localparam): CLK_FRE*1000000/BAUD_RATE. One bit period is CYCLE+1 clocks, matching the transmitter. HALF = CYCLE/2 (integer division).
- `clk` in 1: system clock.
- `rst` in 1: reset, synchronous, active-low.
- `enable_ctrl` in 1: active-low receive enable. 0 = may accept new frames.
- `odd_ctrl` in 1: 1 = frame carries an odd-parity bit after bit 7.
- `stop_ctrl` in 1: 1 = two stop bits, 0 = one.
- `rxd` in 1: asynchronous serial input.
- `rx_data` out 8: last received byte, LSB received first.
- `rx_valid` out 1: one-cycle strobe when a frame completes.
- `parity_err` out 1: parity mismatch of the last frame. Always 0 when parity is disabled.
- `frame_err` out 1: a stop bit was sampled low in the last frame.
- `busy` out 1: high in any state other than IDLE.

## Operation
- `rxd` passes through a 2-flop synchronizer whose flops reset to 0. All logic uses the synchronized value `rxs`.
- Arming: after reset, `rxs` must be seen high for at least 1 cycle before a start can be detected. A line held low from reset is never a start.
- States: IDLE, START, DATA, PARITY, STOP1, STOP2.
- IDLE → START: `rxs` falls (previous 1, current 0) while armed and `enable_ctrl`=0.
  - On this transition, the timer clears.
  - `odd_ctrl` and `stop_ctrl` are latched here. Changes to them mid-frame are ignored.
- Bit timer counts 0..CYCLE and wraps to 0. The sample point is timer==HALF.
- START: if the sample is 1, it is a false start. Return to IDLE with no strobe and no flag update. If the sample is 0, go to DATA.
- DATA: sample 8 bits, LSB first, into a shift register. A 3-bit index counts 0..7. After bit 7, go to PARITY if parity is latched on, otherwise STOP1.
- PARITY: at the sample point, parity_err_next = sample XOR ~^data, so the expected bit is the odd-parity bit. Then go to STOP1.
- STOP1: sample at the sample point; a 0 sets frame_err_next.
  - If two stop bits are latched, go to STOP2.
  - Otherwise, complete the frame and go to IDLE immediately after the sample, without waiting for the period end, to absorb clock drift.
- STOP2: same as STOP1. A 0 at its sample also sets frame_err_next. Then complete the frame.
- Completion: in the next cycle, `rx_data`, `parity_err` and `frame_err` update together and `rx_valid`=1 for exactly one cycle.
  - Outputs hold until the next completion.
  - A frame with errors still completes and strobes.
- `enable_ctrl` going high mid-frame does not abort the frame. It only blocks the next start detection.
- Reset mid-frame: next cycle is IDLE, disarmed, and no strobe is produced for the partial frame.

## Timing
- Reset values: `rx_data`=0, `rx_valid`=0, `parity_err`=0, `frame_err`=0, `busy`=0, state IDLE, timer 0, disarmed.
- Pin-to-detect latency is 2 cycles (synchronizer) plus 1 cycle (edge register). t0 = the cycle START is entered.
- Start sample at t0+HALF. Sample k (k=1 for data bit 0) is at t0+HALF+k*(CYCLE+1).
- STOP1 sample: k=9 without parity, k=10 with parity. STOP2 adds one more period.
- `rx_valid` is high at the final stop sample + 1 cycle.
- The earliest next start detection is the cycle after return to IDLE. Back-to-back frames from the transmitter must be received without loss.

## Structure
- Shared package `uart_pkg` holds:
  - state encoding constants, shared with the transmitter;
  - the CYCLE/HALF computation;
  - the parity helper (odd parity = ~^data).
- Sub-module `uart_rx_sync` holds the 2-flop synchronizer, the falling-edge detect and the armed flag.
- The timer, FSM and shift register live in the top.

## Test plan
Simulate with CLK_FRE=1, BAUD_RATE=100000, giving CYCLE=10, HALF=5 and an 11-clock bit period.
- Byte 0xA5, no parity, 1 stop → `rx_data`=0xA5, one `rx_valid` pulse at t0+5+9*11+1, both errors 0.
- 0x3C with odd parity, parity bit 1 → `parity_err`=0. Same frame with parity bit 0 → `parity_err`=1, `rx_data`=0x3C, still strobes.
- `stop_ctrl`=1, 0x81, second stop driven low → `frame_err`=1, valid at STOP2 sample+1. With both stops high → `frame_err`=0.
- 3-clock low glitch on idle line → no `rx_valid`, `busy` returns to 0 after the start sample. `rxd` held low from reset with no high → no frame detected.
- Transmitter instance looped to `rxd`, random bytes, all four odd/stop combinations, back-to-back sends → every byte matches, no errors.
- `rst` asserted at DATA bit 4 → next cycle IDLE with outputs 0. `enable_ctrl`=1 raised mid-frame → frame completes. A following frame sent while `enable_ctrl`=1 → ignored.
